pixel_write_engine: RTL
=======================

Name: pixel_write_engine

Overview:
- Downstream neighbour of the line drawing stage. Consumes the stream of pixels that stage rasterizes.
- Clips each pixel against the screen, converts (x, y) to a linear frame-buffer address and issues one memory write per visible pixel over an rts/rtr handshake.
- Also provides a full-screen clear sequence that fills the frame buffer with a programmed colour.

Parameters:
- H_RES, 640, horizontal resolution in pixels.
- V_RES, 480, vertical resolution in pixels.
- COORD_WIDTH, 10, width of x and y.
- COLOR_WIDTH, 12, pixel colour width (4:4:4 RGB).
- ADDR_WIDTH, 19, frame-buffer word-address width; must satisfy 2^ADDR_WIDTH >= H_RES*V_RES.

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- in_pixel  in  32  {x[31:22], y[21:12], color[11:0]}
- in_rts  in  1  upstream has pixel
- in_rtr  out  1  block can accept pixel
- clear_req  in  1  single-cycle request to clear frame buffer
- clear_color  in  12  fill colour, sampled when clear_req is accepted
- busy  out  1  high while draining or clearing
- out_addr  out  19  frame-buffer write address
- out_data  out  12  write colour
- out_rts  out  1  write request valid
- out_rtr  in  1  memory accepts write
- pix_count  out  32  visible pixels written since reset (wraps)
- clip_count  out  16  pixels discarded by clipping (saturates at 16'hFFFF)

Behaviour:
- Reset (rst_ low, asynchronous): state=DRAW, stage-A valid=0, out_rts=0, out_addr=0, out_data=0, busy=0, pix_count=0, clip_count=0, clear counter=0. Asserting reset mid-clear or mid-stream abandons all work immediately.
- Handshakes: transfer occurs on a cycle where rts&&rtr at the clock edge. out_addr/out_data must hold stable while out_rts=1 and out_rtr=0.
- Pipeline:
  - Stage A registers the accepted pixel and computes clip = (x>=H_RES)||(y>=V_RES) and addr = y*H_RES + x. The multiply is done at ADDR_WIDTH bits; for the default it is (y<<9)+(y<<7)+x.
  - Output register holds the write.
  - a_adv = a_valid && (clip || !out_rts || out_rtr).
  - in_rtr = (state==DRAW) && (!a_valid || a_adv). This is a combinational full-throughput path with no bubbles.
- Latency: a pixel accepted at edge N appears on out_rts after edge N+1 (valid during cycle N+1→N+2) when the output is free. Throughput is 1 pixel/clk.
- Clipped pixel: leaves stage A without touching the output register; clip_count increments once.
- pix_count increments once per accepted output write in DRAW/DRAIN (out_rts&&out_rtr). Clear writes are not counted.
- FSM:
  - DRAW: normal operation. If clear_req=1, latch clear_color and go to DRAIN. A pixel accepted on the same edge is still processed.
  - DRAIN: in_rtr=0. Stay until !a_valid && (!out_rts || out_rtr). Then go to CLEAR with counter=0.
  - CLEAR: in_rtr=0. Output presents addr=counter, data=latched colour, out_rts=1. Counter increments on each acceptance. When the write at addr H_RES*V_RES-1 is accepted, go to DRAW, out_rts=0, counter=0.
- busy = (state!=DRAW).
- clear_req while in DRAIN or CLEAR is ignored; there is no queueing.
- in_pixel is ignored whenever in_rtr=0.
- Back-pressure: out_rtr low indefinitely stalls the whole pipe with no loss and no duplication. At most 2 pixels are held internally.

Decomposition:
- Shared package holds:
  - H_RES, V_RES, FB_WORDS=H_RES*V_RES
  - coordinate, colour and address widths
  - pixel field bit positions for the 32-bit pixel word (shared with the line drawing stage)
  - FSM state encodings DRAW/DRAIN/CLEAR
- One natural sub-module: fb_addr_calc, a combinational clip plus y*H_RES+x generator with a shift-add specialisation for 640. The FSM and pipeline stay in the top block.

Test Plan:
- Reset then push (x=5,y=10,color=abc) with out_rtr=1 → one write, addr=6405, data=abc, two edges after acceptance; pix_count=1.
- Push x=640,y=0 then x=0,y=480 then x=639,y=479 → only one write, addr=307199; clip_count=2, pix_count=1.
- Stream 8 pixels with out_rtr toggling 1,0,0,1,… → all 8 writes in order, no duplicates; out_addr/out_data stable while stalled; in_rtr drops when 2 are held.
- Two pixels in flight, then clear_req with clear_color=0F0 and out_rtr=1:
  - both pixel writes complete first;
  - then 307200 writes with addr 0..307199 and data 0F0;
  - busy high throughout, in_rtr=0 throughout;
  - pix_count unchanged by the clear writes.
- Second clear_req during CLEAR → ignored: exactly 307200 clear writes; back to DRAW, busy=0.
- rst_ low mid-clear at addr 1000 → out_rts=0, busy=0, counters=0 asynchronously. After release, a new pixel (1,1,fff) produces addr=641.

Source files
------------

// File: rtl/pixel_write_engine_pkg.sv
// Shared constants for the pixel path: screen geometry, field widths,
// the 32-bit pixel word layout used by the line drawing stage, and FSM states.
package pixel_write_engine_pkg;

    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int FB_WORDS    = H_RES * V_RES;
    localparam int COORD_WIDTH = 10;
    localparam int COLOR_WIDTH = 12;
    localparam int ADDR_WIDTH  = 19;

    // pixel word: {x[31:22], y[21:12], color[11:0]}
    localparam int PIX_X_LSB = 22;
    localparam int PIX_Y_LSB = 12;
    localparam int PIX_C_LSB = 0;

    typedef enum logic [1:0] {
        DRAW  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational screen clip and linear frame-buffer address (y*H_RES + x).
// A 640-wide screen uses a shift-add instead of a general multiplier.
module fb_addr_calc
    import pixel_write_engine_pkg::*;
#(
    parameter int H_RES       = pixel_write_engine_pkg::H_RES,
    parameter int V_RES       = pixel_write_engine_pkg::V_RES,
    parameter int COORD_WIDTH = pixel_write_engine_pkg::COORD_WIDTH,
    parameter int ADDR_WIDTH  = pixel_write_engine_pkg::ADDR_WIDTH
) (
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    output logic                   clip,
    output logic [ADDR_WIDTH-1:0]  addr
);

    localparam logic [COORD_WIDTH:0] H_LIM = (COORD_WIDTH+1)'(H_RES);
    localparam logic [COORD_WIDTH:0] V_LIM = (COORD_WIDTH+1)'(V_RES);

    logic [ADDR_WIDTH-1:0] x_ext;
    logic [ADDR_WIDTH-1:0] y_ext;

    assign x_ext = ADDR_WIDTH'(x);
    assign y_ext = ADDR_WIDTH'(y);
    assign clip  = ({1'b0, x} >= H_LIM) || ({1'b0, y} >= V_LIM);

    generate
        if (H_RES == 640) begin : g_shift
            // 640 = 512 + 128
            assign addr = (y_ext << 9) + (y_ext << 7) + x_ext;
        end else begin : g_mul
            localparam logic [ADDR_WIDTH-1:0] H_MUL = ADDR_WIDTH'(H_RES);
            assign addr = y_ext * H_MUL + x_ext;
        end
    endgenerate

endmodule

// File: rtl/pixel_write_engine.sv
// Clips incoming pixels, converts them to frame-buffer writes over rts/rtr,
// and runs a full-screen clear with a programmed colour.
//   state | meaning
//   DRAW  | normal pixel stream, in_rtr may be high
//   DRAIN | clear requested, flushing stage A and output register
//   CLEAR | writing latched colour to every frame-buffer word
module pixel_write_engine
    import pixel_write_engine_pkg::*;
#(
    parameter int H_RES       = pixel_write_engine_pkg::H_RES,
    parameter int V_RES       = pixel_write_engine_pkg::V_RES,
    parameter int COORD_WIDTH = pixel_write_engine_pkg::COORD_WIDTH,
    parameter int COLOR_WIDTH = pixel_write_engine_pkg::COLOR_WIDTH,
    parameter int ADDR_WIDTH  = pixel_write_engine_pkg::ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [31:0]            in_pixel,
    input  logic                   in_rts,
    output logic                   in_rtr,
    input  logic                   clear_req,
    input  logic [COLOR_WIDTH-1:0] clear_color,
    output logic                   busy,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [COLOR_WIDTH-1:0] out_data,
    output logic                   out_rts,
    input  logic                   out_rtr,
    output logic [31:0]            pix_count,
    output logic [15:0]            clip_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES - 1);

    state_t                 state, state_nx;
    logic                   a_valid, a_clip;
    logic [ADDR_WIDTH-1:0]  a_addr;
    logic [COLOR_WIDTH-1:0] a_color;
    logic [COLOR_WIDTH-1:0] clr_color;
    logic [ADDR_WIDTH-1:0]  clr_cnt;
    logic [COORD_WIDTH-1:0] px, py;
    logic                   p_clip;
    logic [ADDR_WIDTH-1:0]  p_addr;
    logic                   a_adv, in_acc, out_acc, drain_done, clear_last;

    assign px = in_pixel[PIX_X_LSB +: COORD_WIDTH];
    assign py = in_pixel[PIX_Y_LSB +: COORD_WIDTH];

    fb_addr_calc #(
        .H_RES       (H_RES),
        .V_RES       (V_RES),
        .COORD_WIDTH (COORD_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_addr (
        .x    (px),
        .y    (py),
        .clip (p_clip),
        .addr (p_addr)
    );

    // stage A drains straight through when it holds a clipped pixel
    assign a_adv      = a_valid && (a_clip || !out_rts || out_rtr);
    assign in_rtr     = (state == DRAW) && (!a_valid || a_adv);
    assign in_acc     = in_rts && in_rtr;
    assign out_acc    = out_rts && out_rtr;
    assign drain_done = !a_valid && (!out_rts || out_rtr);
    assign clear_last = out_acc && (clr_cnt == LAST_ADDR);
    assign busy       = (state != DRAW);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= DRAW;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            DRAW:    if (clear_req)  state_nx = DRAIN;
            DRAIN:   if (drain_done) state_nx = CLEAR;
            CLEAR:   if (clear_last) state_nx = DRAW;
            default: state_nx = DRAW;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            a_valid    <= 1'b0;
            a_clip     <= 1'b0;
            a_addr     <= '0;
            a_color    <= '0;
            clr_color  <= '0;
            clr_cnt    <= '0;
            out_rts    <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            pix_count  <= '0;
            clip_count <= '0;
        end else begin
            if (state == DRAW && clear_req) clr_color <= clear_color;

            if (in_acc) begin
                a_valid <= 1'b1;
                a_clip  <= p_clip;
                a_addr  <= p_addr;
                a_color <= in_pixel[PIX_C_LSB +: COLOR_WIDTH];
            end else if (a_adv) begin
                a_valid <= 1'b0;
            end

            if (state == CLEAR) begin
                if (out_rtr) begin
                    if (clear_last) begin
                        out_rts <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt  <= clr_cnt + ADDR_WIDTH'(1);
                        out_addr <= clr_cnt + ADDR_WIDTH'(1);
                    end
                end
            end else if (state == DRAIN && drain_done) begin
                // first clear write is presented on the DRAIN->CLEAR edge
                out_rts  <= 1'b1;
                out_addr <= '0;
                out_data <= clr_color;
                clr_cnt  <= '0;
            end else if (a_adv && !a_clip) begin
                out_rts  <= 1'b1;
                out_addr <= a_addr;
                out_data <= a_color;
            end else if (out_rtr) begin
                out_rts <= 1'b0;
            end

            if (out_acc && state != CLEAR) pix_count <= pix_count + 32'd1;
            if (a_adv && a_clip && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
        end
    end

endmodule
